// File: rtl/pixel_interp_mc.sv
// Three-stage horizontal interpolator: blends each accepted pixel with the previous one
// per channel using a fractional weight, with nearest-neighbour bypass and blank masking.
module pixel_interp_mc #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned FRACW    = 8,
  parameter int unsigned ROUND    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic                      in_sol,
  input  logic                      in_blank,
  input  logic                      nearest,
  input  logic [FRACW-1:0]          frac,
  input  logic [CHANNELS*WIDTH-1:0] in_pix,
  output logic                      out_valid,
  output logic                      out_blank,
  output logic [CHANNELS*WIDTH-1:0] out_pix
);

  localparam int unsigned PW = CHANNELS * WIDTH;
  localparam int unsigned SW = WIDTH + FRACW + 1;
  localparam int unsigned PPW = WIDTH + FRACW;
  localparam logic [FRACW:0] FULL_WEIGHT = {1'b1, {FRACW{1'b0}}};
  localparam logic [SW-1:0] RND_BIAS = (ROUND != 0) ? (SW'(1) << (FRACW - 1)) : '0;

  // Stage 1 state
  logic [PW-1:0]    r_prev;
  logic             r_s1_valid;
  logic [PW-1:0]    r_s1_x;
  logic [PW-1:0]    r_s1_p;
  logic [FRACW-1:0] r_s1_f;
  logic [FRACW:0]   r_s1_inv;
  logic             r_s1_near;
  logic             r_s1_blank;

  // Stage 2 state
  logic             r_s2_valid;
  logic             r_s2_near;
  logic             r_s2_blank;
  logic [PW-1:0]    r_s2_sel;
  logic [SW-1:0]    r_s2_px [CHANNELS];
  logic [PPW-1:0]   r_s2_pp [CHANNELS];

  logic [PW-1:0]    w_p;
  logic [FRACW:0]   w_inv;
  logic [PW-1:0]    w_sel;
  logic [SW-1:0]    w_px [CHANNELS];
  logic [PPW-1:0]   w_pp [CHANNELS];
  logic [PW-1:0]    w_blend;
  logic [PW-1:0]    w_out;

  // A start-of-line pixel has no left neighbour, so it blends with itself.
  assign w_p   = in_sol ? in_pix : r_prev;
  assign w_inv = FULL_WEIGHT - {1'b0, frac};
  assign w_sel = r_s1_f[FRACW-1] ? r_s1_p : r_s1_x;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_px[c] = SW'(r_s1_x[c*WIDTH +: WIDTH]) * SW'(r_s1_inv);
    assign w_pp[c] = PPW'(r_s1_p[c*WIDTH +: WIDTH]) * PPW'(r_s1_f);
    // Sum cannot exceed (2^WIDTH-1)*2^FRACW + bias, so the shifted result never wraps.
    assign w_blend[c*WIDTH +: WIDTH] =
        WIDTH'((r_s2_px[c] + SW'(r_s2_pp[c]) + RND_BIAS) >> FRACW);
  end

  always_comb begin
    w_out = w_blend;
    if (r_s2_near) begin
      w_out = r_s2_sel;
    end
    if (r_s2_blank) begin
      w_out = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_p     <= '0;
      r_s1_f     <= '0;
      r_s1_inv   <= '0;
      r_s1_near  <= 1'b0;
      r_s1_blank <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_prev     <= in_pix;
        r_s1_x     <= in_pix;
        r_s1_p     <= w_p;
        r_s1_f     <= frac;
        r_s1_inv   <= w_inv;
        r_s1_near  <= nearest;
        r_s1_blank <= in_blank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_near  <= 1'b0;
      r_s2_blank <= 1'b0;
      r_s2_sel   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_s2_px[c] <= '0;
        r_s2_pp[c] <= '0;
      end
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_near  <= r_s1_near;
        r_s2_blank <= r_s1_blank;
        r_s2_sel   <= w_sel;
        for (int c = 0; c < CHANNELS; c++) begin
          r_s2_px[c] <= w_px[c];
          r_s2_pp[c] <= w_pp[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_blank <= 1'b0;
      out_pix   <= '0;
    end else begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_blank <= r_s2_blank;
        out_pix   <= w_out;
      end
    end
  end

endmodule

// File: tb/tb_pixel_interp_mc.sv
// Randomised bench for pixel_interp_mc: two instances (rounding on/off) checked every cycle
// against an arithmetic reference model, plus hand-computed literal expectations.
module tb_pixel_interp_mc;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int F  = 8;
  localparam int PW = CH * W;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sol = 1'b0;
  logic          in_blank = 1'b0;
  logic          nearest = 1'b0;
  logic [F-1:0]  frac = '0;
  logic [PW-1:0] in_pix = '0;
  logic          ov1, ob1, ov0, ob0;
  logic [PW-1:0] op1, op0;

  always #5 clk = ~clk;

  pixel_interp_mc #(.CHANNELS(CH), .WIDTH(W), .FRACW(F), .ROUND(1)) u_dut_r1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sol(in_sol),
    .in_blank(in_blank), .nearest(nearest), .frac(frac), .in_pix(in_pix),
    .out_valid(ov1), .out_blank(ob1), .out_pix(op1)
  );

  pixel_interp_mc #(.CHANNELS(CH), .WIDTH(W), .FRACW(F), .ROUND(0)) u_dut_r0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sol(in_sol),
    .in_blank(in_blank), .nearest(nearest), .frac(frac), .in_pix(in_pix),
    .out_valid(ov0), .out_blank(ob0), .out_pix(op0)
  );

  typedef struct {
    bit            v;
    bit            b;
    logic [PW-1:0] p1;
    logic [PW-1:0] p0;
    bit            hl;
    logic [PW-1:0] l1;
    logic [PW-1:0] l0;
  } ent_t;

  ent_t          q[$];   // samples in flight, oldest first
  ent_t          e;      // expected output registers
  logic [PW-1:0] m_prev;
  bit            started = 1'b0;
  bit            cur_hl = 1'b0;
  logic [PW-1:0] cur_l1, cur_l0;
  int            n_vec = 0;
  int            n_bad = 0;

  function automatic logic [PW-1:0] model_pix(logic [PW-1:0] x, logic [PW-1:0] p,
                                              logic [F-1:0] f, bit near, bit blank, bit rnd);
    logic [PW-1:0] r;
    r = '0;
    if (blank) return r;
    for (int c = 0; c < CH; c++) begin
      int xc = int'(x[c*W +: W]);
      int pc = int'(p[c*W +: W]);
      int fi = int'(f);
      int v;
      if (near) v = f[F-1] ? pc : xc;
      else v = (xc * ((1 << F) - fi) + pc * fi + (rnd ? (1 << (F - 1)) : 0)) / (1 << F);
      r[c*W +: W] = W'(v);
    end
    return r;
  endfunction

  task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: inputs are already applied; update the model from what the edge samples.
  task automatic step();
    ent_t n;
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      e = '{default: '0};
      m_prev = '0;
    end else begin
      if (q.size() == 2) begin
        ent_t o;
        o = q.pop_front();
        e.v  = o.v;
        e.hl = o.v && o.hl;
        e.l1 = o.l1;
        e.l0 = o.l0;
        if (o.v) begin
          e.b  = o.b;
          e.p1 = o.p1;
          e.p0 = o.p0;
        end
      end else begin
        e.v  = 1'b0;
        e.hl = 1'b0;
      end
      n = '{default: '0};
      n.v = in_valid;
      if (in_valid) begin
        logic [PW-1:0] p;
        p    = in_sol ? in_pix : m_prev;
        n.b  = in_blank;
        n.p1 = model_pix(in_pix, p, frac, nearest, in_blank, 1'b1);
        n.p0 = model_pix(in_pix, p, frac, nearest, in_blank, 1'b0);
        n.hl = cur_hl;
        n.l1 = cur_l1;
        n.l0 = cur_l0;
        m_prev = in_pix;
      end
      q.push_back(n);
    end
    started = 1'b1;
    #1;
  endtask

  task automatic send(bit v, bit sol, bit blank, bit near, logic [F-1:0] f,
                      logic [PW-1:0] px, bit hl, logic [PW-1:0] l1, logic [PW-1:0] l0);
    in_valid = v;
    in_sol   = sol;
    in_blank = blank;
    nearest  = near;
    frac     = f;
    in_pix   = px;
    cur_hl   = hl;
    cur_l1   = l1;
    cur_l0   = l0;
    step();
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("valid_r1", PW'(ov1), PW'(e.v));
      check("valid_r0", PW'(ov0), PW'(e.v));
      check("blank_r1", PW'(ob1), PW'(e.b));
      check("blank_r0", PW'(ob0), PW'(e.b));
      check("pix_r1", op1, e.p1);
      check("pix_r0", op0, e.p0);
      if (e.hl) begin
        check("literal_r1", op1, e.l1);
        check("literal_r0", op0, e.l0);
        check("model_vs_literal", e.p1, e.l1);
      end
    end
  end

  initial begin
    e = '{default: '0};
    m_prev = '0;
    reset_n = 1'b0;
    send(1, 0, 0, 0, 8'h00, 24'h0, 0, 24'h0, 24'h0);
    send(0, 0, 0, 0, 8'h00, 24'h0, 0, 24'h0, 24'h0);
    reset_n = 1'b1;

    // Passthrough
    send(1, 0, 0, 0, 8'h00, 24'h102030, 1, 24'h102030, 24'h102030);
    send(1, 0, 0, 0, 8'h00, 24'hA0B0C0, 1, 24'hA0B0C0, 24'hA0B0C0);
    // Midpoint rounding
    send(1, 0, 0, 0, 8'h00, 24'h212121, 1, 24'h212121, 24'h212121);
    send(1, 0, 0, 0, 8'h80, 24'h101010, 1, 24'h191919, 24'h181818);
    // Full scale
    send(1, 0, 0, 0, 8'h00, 24'hFFFFFF, 1, 24'hFFFFFF, 24'hFFFFFF);
    send(1, 0, 0, 0, 8'h80, 24'hFFFFFF, 1, 24'hFFFFFF, 24'hFFFFFF);
    send(1, 0, 0, 0, 8'hFF, 24'hFFFFFF, 1, 24'hFFFFFF, 24'hFFFFFF);
    // Start of line
    send(1, 0, 0, 0, 8'h00, 24'h000000, 1, 24'h000000, 24'h000000);
    send(1, 1, 0, 0, 8'hFF, 24'h808080, 1, 24'h808080, 24'h808080);
    send(1, 0, 0, 0, 8'h80, 24'h000000, 1, 24'h404040, 24'h404040);
    // Nearest and blank; the blanked pixel still becomes prev
    send(1, 0, 0, 0, 8'h00, 24'h111111, 1, 24'h111111, 24'h111111);
    send(1, 0, 0, 1, 8'h7F, 24'h222222, 1, 24'h222222, 24'h222222);
    send(1, 0, 0, 0, 8'h00, 24'h111111, 1, 24'h111111, 24'h111111);
    send(1, 0, 0, 1, 8'h80, 24'h222222, 1, 24'h111111, 24'h111111);
    send(1, 0, 1, 0, 8'h00, 24'h333333, 1, 24'h000000, 24'h000000);
    send(1, 0, 0, 1, 8'hFF, 24'h444444, 1, 24'h333333, 24'h333333);
    // Reset mid-stream with 3 pixels in flight; in_valid during reset is ignored
    send(1, 0, 0, 0, 8'h10, 24'h123456, 0, 24'h0, 24'h0);
    send(1, 0, 0, 0, 8'h20, 24'h654321, 0, 24'h0, 24'h0);
    send(1, 0, 0, 0, 8'h30, 24'hABCDEF, 0, 24'h0, 24'h0);
    reset_n = 1'b0;
    send(1, 0, 0, 0, 8'h00, 24'hEEEEEE, 0, 24'h0, 24'h0);
    reset_n = 1'b1;
    send(1, 0, 0, 0, 8'hFF, 24'h646464, 1, 24'h000000, 24'h000000);
    send(0, 1, 0, 0, 8'h00, 24'h999999, 0, 24'h0, 24'h0);
    send(1, 0, 0, 0, 8'h00, 24'h5A5A5A, 1, 24'h5A5A5A, 24'h5A5A5A);
    for (int i = 0; i < 4; i++) send(0, 0, 0, 0, 8'h00, 24'h0, 0, 24'h0, 24'h0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(99) != 0);
      send($urandom_range(3) != 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
           $urandom_range(3) == 0, F'($urandom), PW'($urandom), 0, 24'h0, 24'h0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send(0, 0, 0, 0, 8'h00, 24'h0, 0, 24'h0, 24'h0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
